// File: rtl/md5_padder.sv
// md5_padder: MD5 padding front end that packs a byte stream into 512-bit blocks emitted as four 128-bit quarters.
// Optional feature MD5_PAD_BYTESWAP_EN: byte-reverse each 32-bit word of data_o (RFC 1321 little-endian words).
module md5_padder #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    input  logic         out_ready,
    output logic [127:0] data_o,
    output logic         en1,
    output logic         en2,
    output logic         en3,
    output logic         en4,
    output logic         blk_last,
    output logic         busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PAD  = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    state_t           state_r;
    logic [511:0]     buf_r;          // byte 0 sits at [511:504]
    logic [5:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             need_len_r;     // 0x80 already written, only zero fill remains
    logic             last_blk_r;
    logic             ret_pad_r;
    logic             active_r;
    logic [2:0]       q_r;
    logic             in_ready_r;
    logic [127:0]     data_r;
    logic             en1_r;
    logic             en2_r;
    logic             en3_r;
    logic             en4_r;
    logic             blk_last_r;
    logic             busy_r;

    logic             xfer_s;
    logic [8:0]       wpos_s;
    logic [8:0]       qpos_s;
    logic [7:0]       pad_byte_s;
    logic [63:0]      bitlen_s;

    // Length bytes in RFC 1321 order: least significant byte lands at buffer byte 56.
    function automatic logic [63:0] len_bytes(input logic [63:0] len);
        return {len[7:0],   len[15:8],  len[23:16], len[31:24],
                len[39:32], len[47:40], len[55:48], len[63:56]};
    endfunction

    // Output byte order of one quarter.
    function automatic logic [127:0] out_order(input logic [127:0] q);
`ifdef MD5_PAD_BYTESWAP_EN
        return {q[103:96], q[111:104], q[119:112], q[127:120],
                q[71:64],  q[79:72],   q[87:80],   q[95:88],
                q[39:32],  q[47:40],   q[55:48],   q[63:56],
                q[7:0],    q[15:8],    q[23:16],   q[31:24]};
`else
        return q;
`endif
    endfunction

    // Handshake, buffer addressing, pad byte and bit length.
    always_comb begin
        xfer_s     = in_valid & in_ready_r;
        wpos_s     = {~idx_r, 3'b000};
        qpos_s     = {~q_r[1:0], 7'b0000000};
        pad_byte_s = need_len_r ? 8'h00 : 8'h80;
        bitlen_s   = 64'(cnt_r) << 3'd3;
    end

    // Padder state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            buf_r      <= 512'd0;
            idx_r      <= 6'd0;
            cnt_r      <= '0;
            need_len_r <= 1'b0;
            last_blk_r <= 1'b0;
            ret_pad_r  <= 1'b0;
            active_r   <= 1'b0;
            q_r        <= 3'd0;
            in_ready_r <= 1'b0;
            data_r     <= 128'd0;
            en1_r      <= 1'b0;
            en2_r      <= 1'b0;
            en3_r      <= 1'b0;
            en4_r      <= 1'b0;
            blk_last_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_LOAD: begin
                    in_ready_r <= 1'b1;
                    if (xfer_s && (in_keep || in_last)) begin
                        state_r    <= S_LOAD;
                        busy_r     <= 1'b1;
                        need_len_r <= 1'b0;
                        if (in_keep) begin
                            buf_r[wpos_s +: 8] <= in_data;
                            idx_r              <= idx_r + 6'd1;
                            cnt_r              <= cnt_r + CNT_W'(1);
                        end
                        // A full block always goes out first, even when it carries the last byte
                        if (in_keep && (idx_r == 6'd63)) begin
                            state_r    <= S_EMIT;
                            in_ready_r <= 1'b0;
                            last_blk_r <= 1'b0;
                            ret_pad_r  <= in_last;
                        end else if (in_last) begin
                            state_r    <= S_PAD;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    buf_r[wpos_s +: 8] <= pad_byte_s;
                    need_len_r         <= 1'b1;
                    idx_r              <= idx_r + 6'd1;
                    if (idx_r == 6'd55) begin
                        buf_r[63:0] <= len_bytes(bitlen_s);
                        state_r     <= S_EMIT;
                        last_blk_r  <= 1'b1;
                    end else if (idx_r == 6'd63) begin
                        state_r    <= S_EMIT;
                        last_blk_r <= 1'b0;
                        ret_pad_r  <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (!active_r) begin
                        if (out_ready) begin
                            active_r   <= 1'b1;
                            q_r        <= 3'd1;
                            data_r     <= out_order(buf_r[511:384]);
                            en1_r      <= 1'b1;
                            blk_last_r <= last_blk_r;
                        end
                    end else if (q_r != 3'd4) begin
                        data_r <= out_order(buf_r[qpos_s +: 128]);
                        q_r    <= q_r + 3'd1;
                        en1_r  <= 1'b0;
                        en2_r  <= (q_r == 3'd1);
                        en3_r  <= (q_r == 3'd2);
                        en4_r  <= (q_r == 3'd3);
                    end else begin
                        // Strobes end here; in_ready stays low through the en4 cycle
                        en4_r      <= 1'b0;
                        active_r   <= 1'b0;
                        q_r        <= 3'd0;
                        blk_last_r <= 1'b0;
                        if (last_blk_r) begin
                            state_r    <= S_IDLE;
                            idx_r      <= 6'd0;
                            cnt_r      <= '0;
                            last_blk_r <= 1'b0;
                            ret_pad_r  <= 1'b0;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end else if (ret_pad_r) begin
                            state_r <= S_PAD;
                        end else begin
                            state_r    <= S_LOAD;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign data_o   = data_r;
    assign en1      = en1_r;
    assign en2      = en2_r;
    assign en3      = en3_r;
    assign en4      = en4_r;
    assign blk_last = blk_last_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_md5_padder.sv
// tb_md5_padder: directed and randomized messages checked against a padded-byte-stream reference model.
module tb_md5_padder;
    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [127:0] d;
        logic [3:0]   en;
        logic         bl;
        logic         ir;
        int           cyc;
    } rec_t;

`ifdef MD5_PAD_BYTESWAP_EN
    localparam logic [127:0] ABC_Q1 = 128'h80636261_00000000_00000000_00000000;
    localparam logic [127:0] ABC_Q4 = 128'h00000000_00000000_00000018_00000000;
`else
    localparam logic [127:0] ABC_Q1 = 128'h61626380_00000000_00000000_00000000;
    localparam logic [127:0] ABC_Q4 = 128'h00000000_00000000_18000000_00000000;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_keep;
    logic         in_last;
    logic         out_ready;
    logic [127:0] data_o;
    logic         en1, en2, en3, en4;
    logic         blk_last;
    logic         busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    rec_t recs[$];
    rec_t mon_r;

    md5_padder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .out_ready(out_ready),
        .data_o(data_o), .en1(en1), .en2(en2), .en3(en3), .en4(en4),
        .blk_last(blk_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every strobed quarter, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (en1 | en2 | en3 | en4) begin
            mon_r.d   = data_o;
            mon_r.en  = {en1, en2, en3, en4};
            mon_r.bl  = blk_last;
            mon_r.ir  = in_ready;
            mon_r.cyc = cyc;
            recs.push_back(mon_r);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: message, 0x80, zeros to 56 mod 64, then 64-bit bit length LSB first.
    function automatic bytes_t model_pad(input bytes_t msg);
        bytes_t      p;
        logic [63:0] bits;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 0; k < 8; k++) p.push_back(bits[8*k +: 8]);
        return p;
    endfunction

    function automatic logic [127:0] model_quarter(input bytes_t pad, input int qi);
        logic [127:0] r;
        r = 128'd0;
        for (int j = 0; j < 16; j++) begin
`ifdef MD5_PAD_BYTESWAP_EN
            r[96 - 32*(j/4) + 8*(j%4) +: 8] = pad[16*qi + j];
`else
            r[120 - 8*j +: 8] = pad[16*qi + j];
`endif
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic keep, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_keep = keep; in_last = last;
        while (!in_ready && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("send wait", 128'(t < 600), 128'd1);
        @(posedge clk);
    endtask

    task automatic send_msg(input bytes_t msg, input logic empty_end, input int stall_pct);
        for (int i = 0; i < msg.size(); i++) begin
            if ($urandom_range(0, 99) < stall_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            send_byte(msg[i], 1'b1, (i == msg.size() - 1) && !empty_end);
        end
        if (empty_end) send_byte(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_keep = 1'b0;
    endtask

    task automatic check_msg(input bytes_t msg, input string tag);
        bytes_t pad;
        int     nq;
        int     t = 0;
        pad = model_pad(msg);
        nq  = pad.size() / 16;
        while (recs.size() < nq && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " quarters"}, 128'(recs.size() >= nq), 128'd1);
        for (int i = 0; i < nq && i < recs.size(); i++) begin
            chk($sformatf("%s q%0d data", tag, i), recs[i].d, model_quarter(pad, i));
            chk($sformatf("%s q%0d en", tag, i), 128'(recs[i].en), 128'(4'b1000 >> (i % 4)));
            chk($sformatf("%s q%0d blk_last", tag, i), 128'(recs[i].bl), 128'((i / 4) == (nq / 4 - 1)));
            chk($sformatf("%s q%0d in_ready", tag, i), 128'(recs[i].ir), 128'd0);
            if ((i % 4) != 0)
                chk($sformatf("%s q%0d gap", tag, i), 128'(recs[i].cyc), 128'(recs[i-1].cyc + 1));
        end
        repeat (4) @(negedge clk);
        chk({tag, " no extra"}, 128'(recs.size()), 128'(nq));
        chk({tag, " idle busy"}, 128'(busy), 128'd0);
        chk({tag, " idle in_ready"}, 128'(in_ready), 128'd1);
        chk({tag, " data hold"}, data_o, model_quarter(pad, nq - 1));
    endtask

    task automatic run_msg(input bytes_t msg, input logic empty_end, input int stall_pct, input string tag);
        recs.delete();
        send_msg(msg, empty_end, stall_pct);
        check_msg(msg, tag);
    endtask

    initial begin
        bytes_t m;
        bytes_t abc;
        int     lens[14];
        logic   ee;
        abc = '{8'h61, 8'h62, 8'h63};
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_keep = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 128'(in_ready), 128'd0);
        chk("rst data_o", data_o, 128'd0);
        chk("rst en", 128'({en1, en2, en3, en4}), 128'd0);
        chk("rst blk_last", 128'(blk_last), 128'd0);
        chk("rst busy", 128'(busy), 128'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", 128'(in_ready), 128'd1);

        run_msg(abc, 1'b0, 0, "abc");
        chk("abc Q1 literal", (recs.size() > 0) ? recs[0].d : 128'bx, ABC_Q1);
        chk("abc Q4 literal", (recs.size() > 3) ? recs[3].d : 128'bx, ABC_Q4);

        m = {};
        run_msg(m, 1'b1, 0, "empty");

        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'(i));
        run_msg(m, 1'b0, 0, "m56");

        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0, 0, "m64");

        // Downstream holds off the block
        recs.delete();
        out_ready = 1'b0;
        send_msg(abc, 1'b0, 0);
        repeat (80) @(negedge clk);
        chk("hold no strobe", 128'(recs.size()), 128'd0);
        chk("hold busy", 128'(busy), 128'd1);
        chk("hold en1 low", 128'(en1), 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold en1 next", 128'(en1), 128'd1);
        check_msg(abc, "abc_hold");

        // Abort a message part way through
        recs.delete();
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("abort in_ready", 128'(in_ready), 128'd0);
        chk("abort data_o", data_o, 128'd0);
        chk("abort en", 128'({en1, en2, en3, en4}), 128'd0);
        chk("abort blk_last", 128'(blk_last), 128'd0);
        chk("abort busy", 128'(busy), 128'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort release in_ready", 128'(in_ready), 128'd1);
        repeat (70) @(negedge clk);
        chk("abort no strobe", 128'(recs.size()), 128'd0);
        run_msg(abc, 1'b0, 0, "abc_after_abort");
        chk("abc2 Q1 literal", (recs.size() > 0) ? recs[0].d : 128'bx, ABC_Q1);

        // Randomized data, stalls and end style around the block boundaries
        lens = '{1, 2, 54, 55, 56, 57, 63, 64, 65, 119, 120, 128, 0, 0};
        lens[13] = $urandom_range(3, 140);
        for (int n = 0; n < 14; n++) begin
            m = {};
            for (int i = 0; i < lens[n]; i++) m.push_back(8'($urandom));
            ee = (lens[n] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            run_msg(m, ee, 25, $sformatf("rnd%0d_len%0d", n, lens[n]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
